// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// The controller owns the master side; the datapath owns the slave side.
interface multicycle_controller_if #(
  parameter int ALUCTR_W = 4,
  parameter int NPCOP_W  = 4
);
  logic [5:0]          op;
  logic [5:0]          func;
  logic                zero;
  logic                i_ready;
  logic                d_ready;
  logic                PCWr;
  logic                IRWr;
  logic                RegDst;
  logic                LinkWr;
  logic                ALUSrc;
  logic                MemtoReg;
  logic                RegWr;
  logic                MemRd;
  logic                MemWr;
  logic                ExtOp;
  logic                if_branch;
  logic [ALUCTR_W-1:0] ALUctr;
  logic [NPCOP_W-1:0]  NPCop;
  logic                illegal_instr;
  logic                bus_error;
  logic [2:0]          state;

  modport master (
    input  op, func, zero, i_ready, d_ready,
    output PCWr, IRWr, RegDst, LinkWr, ALUSrc,
    output MemtoReg, RegWr, MemRd, MemWr, ExtOp,
    output if_branch, ALUctr, NPCop,
    output illegal_instr, bus_error, state
  );

  modport slave (
    output op, func, zero, i_ready, d_ready,
    input  PCWr, IRWr, RegDst, LinkWr, ALUSrc,
    input  MemtoReg, RegWr, MemRd, MemWr, ExtOp,
    input  if_branch, ALUctr, NPCop,
    input  illegal_instr, bus_error, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: IF/ID/EX/MEM/WB sequencing with
// memory-ready handshake, optional wait timeout and illegal-op trap.
module multicycle_controller #(
  parameter int ALUCTR_W    = 4,
  parameter int NPCOP_W     = 4,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_e;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_JR  = 6'b001000;

  localparam logic [3:0] A_AND   = 4'b0000;
  localparam logic [3:0] A_OR    = 4'b0001;
  localparam logic [3:0] A_ADD   = 4'b0010;
  localparam logic [3:0] A_XOR   = 4'b0011;
  localparam logic [3:0] A_ORI   = 4'b0100;
  localparam logic [3:0] A_ADDIU = 4'b0101;
  localparam logic [3:0] A_SUB   = 4'b0110;
  localparam logic [3:0] A_ADDI  = 4'b0111;
  localparam logic [3:0] A_SLL   = 4'b1000;
  localparam logic [3:0] A_SLT   = 4'b1001;
  localparam logic [3:0] A_LUI   = 4'b1111;

  localparam logic [3:0] N_JUMP = 4'b0000;
  localparam logic [3:0] N_JAL  = 4'b0001;
  localparam logic [3:0] N_BEQ  = 4'b0010;
  localparam logic [3:0] N_BNE  = 4'b0011;
  localparam logic [3:0] N_JR   = 4'b1000;
  localparam logic [3:0] N_ADD4 = 4'b1111;

  localparam int CW = 16;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ill_q, ill_d;
  logic          berr_q, berr_d;

  logic [3:0] dec_alu, dec_npc;
  logic       dec_dst, dec_src, dec_m2r, dec_ext, dec_br;
  logic       legal;
  logic       is_j, is_jal, is_jr, is_beq, is_bne, is_lw, is_sw;

  always_comb begin
    dec_alu = A_AND;
    dec_dst = 1'b0;
    dec_src = 1'b0;
    dec_m2r = 1'b0;
    dec_ext = 1'b0;
    dec_br  = 1'b0;
    legal   = 1'b1;
    is_j    = 1'b0;
    is_jal  = 1'b0;
    is_jr   = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    unique case (bus.op)
      OP_R: begin
        unique case (bus.func)
          F_ADD:   dec_alu = A_ADD;
          F_SUB:   dec_alu = A_SUB;
          F_AND:   dec_alu = A_AND;
          F_OR:    dec_alu = A_OR;
          F_SLT:   dec_alu = A_SLT;
          F_XOR:   dec_alu = A_XOR;
          F_SLL:   dec_alu = A_SLL;
          F_JR:    is_jr   = 1'b1;
          default: legal   = 1'b0;
        endcase
      end
      OP_ADDIU: begin
        dec_alu = A_ADDIU;
        dec_ext = 1'b1;
        dec_dst = 1'b1;
        dec_src = 1'b1;
      end
      OP_ADDI: begin
        dec_alu = A_ADDI;
        dec_ext = 1'b1;
        dec_dst = 1'b1;
        dec_src = 1'b1;
      end
      OP_ORI: begin
        dec_alu = A_ORI;
        dec_dst = 1'b1;
        dec_src = 1'b1;
      end
      OP_LUI: begin
        dec_alu = A_LUI;
        dec_dst = 1'b1;
        dec_src = 1'b1;
      end
      OP_LW: begin
        dec_alu = A_ADD;
        dec_ext = 1'b1;
        dec_m2r = 1'b1;
        dec_dst = 1'b1;
        dec_src = 1'b1;
        is_lw   = 1'b1;
      end
      OP_SW: begin
        dec_alu = A_ADD;
        dec_ext = 1'b1;
        dec_dst = 1'b1;
        dec_src = 1'b1;
        is_sw   = 1'b1;
      end
      OP_BEQ: begin
        dec_alu = A_SUB;
        dec_ext = 1'b1;
        dec_br  = 1'b1;
        is_beq  = 1'b1;
      end
      OP_BNE: begin
        dec_alu = A_SUB;
        dec_ext = 1'b1;
        dec_br  = 1'b1;
        is_bne  = 1'b1;
      end
      OP_J:    is_j   = 1'b1;
      OP_JAL:  is_jal = 1'b1;
      default: legal  = 1'b0;
    endcase
  end

  always_comb begin
    dec_npc = N_ADD4;
    unique case (1'b1)
      is_j:    dec_npc = N_JUMP;
      is_jal:  dec_npc = N_JAL;
      is_jr:   dec_npc = N_JR;
      is_beq:  dec_npc = bus.zero ? N_BEQ : N_ADD4;
      is_bne:  dec_npc = bus.zero ? N_ADD4 : N_BNE;
      default: dec_npc = N_ADD4;
    endcase
  end

  // Last permitted wait cycle; ready on this cycle still completes.
  logic at_lim;
  assign at_lim = (MEM_TIMEOUT > 0) &&
                  (int'(cnt_q) == MEM_TIMEOUT - 1);

  logic pc_wr, ir_wr, reg_wr, link_wr, mem_rd, mem_wr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ill_d   = ill_q;
    berr_d  = berr_q;
    pc_wr   = 1'b0;
    ir_wr   = 1'b0;
    reg_wr  = 1'b0;
    link_wr = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    unique case (state_q)
      S_IF: begin
        if (bus.i_ready) begin
          ir_wr   = 1'b1;
          cnt_d   = '0;
          state_d = S_ID;
        end else if (at_lim) begin
          cnt_d   = '0;
          berr_d  = 1'b1;
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ID: begin
        if (!legal) begin
          ill_d   = 1'b1;
          state_d = S_TRAP;
        end else if (is_j || is_jr) begin
          pc_wr   = 1'b1;
          state_d = S_IF;
        end else if (is_jal) begin
          pc_wr   = 1'b1;
          reg_wr  = 1'b1;
          link_wr = 1'b1;
          state_d = S_IF;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        if (is_beq || is_bne) begin
          pc_wr   = 1'b1;
          state_d = S_IF;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_rd = is_lw;
        mem_wr = is_sw;
        if (bus.d_ready) begin
          cnt_d = '0;
          if (is_sw) begin
            pc_wr   = 1'b1;
            state_d = S_IF;
          end else begin
            state_d = S_WB;
          end
        end else if (at_lim) begin
          cnt_d   = '0;
          berr_d  = 1'b1;
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        reg_wr  = 1'b1;
        pc_wr   = 1'b1;
        state_d = S_IF;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IF;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
      berr_q  <= berr_d;
    end
  end

  logic dec_on;
  assign dec_on = (state_q != S_IF);

  // Strobes are masked by rst_n so nothing fires while reset is held.
  assign bus.PCWr   = pc_wr & rst_n;
  assign bus.IRWr   = ir_wr & rst_n;
  assign bus.RegWr  = reg_wr & rst_n;
  assign bus.LinkWr = link_wr & rst_n;
  assign bus.MemRd  = mem_rd & rst_n;
  assign bus.MemWr  = mem_wr & rst_n;

  assign bus.RegDst    = dec_on & dec_dst;
  assign bus.ALUSrc    = dec_on & dec_src;
  assign bus.MemtoReg  = dec_on & dec_m2r;
  assign bus.ExtOp     = dec_on & dec_ext;
  assign bus.if_branch = dec_on & dec_br;
  assign bus.ALUctr    = dec_on ? ALUCTR_W'(dec_alu) : '0;
  assign bus.NPCop     = dec_on ? NPCOP_W'(dec_npc)
                                : NPCOP_W'(N_ADD4);

  assign bus.illegal_instr = ill_q;
  assign bus.bus_error     = berr_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle vector table plus
// hand sequences for trap, async reset and memory timeout.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] func = '0;
  logic       zero = 1'b0;
  logic       i_ready = 1'b0;
  logic       d_ready = 1'b0;

  always #5 clk = ~clk;

  multicycle_controller_if #(.ALUCTR_W(4), .NPCOP_W(4)) i0 ();
  multicycle_controller_if #(.ALUCTR_W(4), .NPCOP_W(4)) i4 ();

  assign i0.op = op;
  assign i0.func = func;
  assign i0.zero = zero;
  assign i0.i_ready = i_ready;
  assign i0.d_ready = d_ready;
  assign i4.op = op;
  assign i4.func = func;
  assign i4.zero = zero;
  assign i4.i_ready = i_ready;
  assign i4.d_ready = d_ready;

  multicycle_controller #(
    .ALUCTR_W(4), .NPCOP_W(4), .MEM_TIMEOUT(0)
  ) u0 (.clk(clk), .rst_n(rst_n), .bus(i0.master));

  multicycle_controller #(
    .ALUCTR_W(4), .NPCOP_W(4), .MEM_TIMEOUT(4)
  ) u4 (.clk(clk), .rst_n(rst_n), .bus(i4.master));

  // {state, PCWr,IRWr,RegWr,LinkWr,MemRd,MemWr, NPCop, ALUctr,
  //  RegDst,ALUSrc,MemtoReg,ExtOp,if_branch, illegal,bus_error}
  logic [23:0] act0, act4;
  assign act0 = {i0.state, i0.PCWr, i0.IRWr, i0.RegWr,
                 i0.LinkWr, i0.MemRd, i0.MemWr, i0.NPCop,
                 i0.ALUctr, i0.RegDst, i0.ALUSrc, i0.MemtoReg,
                 i0.ExtOp, i0.if_branch, i0.illegal_instr,
                 i0.bus_error};
  assign act4 = {i4.state, i4.PCWr, i4.IRWr, i4.RegWr,
                 i4.LinkWr, i4.MemRd, i4.MemWr, i4.NPCop,
                 i4.ALUctr, i4.RegDst, i4.ALUSrc, i4.MemtoReg,
                 i4.ExtOp, i4.if_branch, i4.illegal_instr,
                 i4.bus_error};

  localparam logic [2:0] SIF = 3'd0, SID = 3'd1, SEX = 3'd2;
  localparam logic [2:0] SMEM = 3'd3, SWB = 3'd4, STRAP = 3'd5;

  localparam logic [5:0] B0   = 6'b000000;
  localparam logic [5:0] B_IR = 6'b010000;
  localparam logic [5:0] B_WB = 6'b101000;
  localparam logic [5:0] B_PC = 6'b100000;
  localparam logic [5:0] B_JL = 6'b101100;
  localparam logic [5:0] B_SW = 6'b100001;
  localparam logic [5:0] B_MR = 6'b000010;
  localparam logic [5:0] B_MW = 6'b000001;

  localparam logic [5:0] RT = 6'h00, FADD = 6'b100000;
  localparam logic [5:0] FJR = 6'b001000, ORI = 6'b001101;
  localparam logic [5:0] JAL = 6'b000011, JMP = 6'b000010;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101;
  localparam logic [5:0] SW = 6'b101011, LW = 6'b100011;
  localparam logic [5:0] BAD = 6'b111111;

  localparam logic [4:0] M0 = 5'b00000, M_ORI = 5'b11000;
  localparam logic [4:0] M_LW = 5'b11110, M_SW = 5'b11010;
  localparam logic [4:0] M_BR = 5'b00011;

  localparam logic [3:0] N4 = 4'hF;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  func;
    logic        z;
    logic        ir;
    logic        dr;
    logic [23:0] e0;
    logic [23:0] e4;
  } vec_t;

  typedef struct {
    logic [23:0] e0;
    logic [23:0] e4;
    string       nm;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];
  int   total = 0;
  int   bad = 0;
  int   stepn = 0;

  function automatic vec_t mk(
    input logic [5:0] o, input logic [5:0] f, input logic z,
    input logic ir, input logic dr, input logic [2:0] st,
    input logic [5:0] sb, input logic [3:0] np,
    input logic [3:0] al, input logic [4:0] ms,
    input logic [1:0] fl);
    vec_t v;
    v.op = o;
    v.func = f;
    v.z = z;
    v.ir = ir;
    v.dr = dr;
    v.e0 = {st, sb, np, al, ms, fl};
    v.e4 = v.e0;
    return v;
  endfunction

  function automatic vec_t with4(input vec_t v,
                                 input logic [23:0] e);
    vec_t r;
    r = v;
    r.e4 = e;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [23:0] a,
                     input logic [23:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h",
               nm, stepn, a, e);
    end
  endtask

  // Called at a falling edge; leaves at the next falling edge.
  task automatic step(input vec_t v, input string nm);
    sb_t e;
    op = v.op;
    func = v.func;
    zero = v.z;
    i_ready = v.ir;
    d_ready = v.dr;
    sbq.push_back('{e0: v.e0, e4: v.e4, nm: nm});
    #1;
    e = sbq.pop_front();
    chk({e.nm, "/t0"}, act0, e.e0);
    chk({e.nm, "/t4"}, act4, e.e4);
    stepn++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [23:0] idle_e;
  logic [23:0] trap_sw;

  initial begin
    idle_e  = {SIF, B0, N4, 4'h0, M0, 2'b00};
    trap_sw = {STRAP, B0, N4, 4'h2, M_SW, 2'b01};

    // add
    tbl.push_back(mk(RT, FADD, 0, 1, 0, SIF, B_IR, N4, 0, M0, 0));
    tbl.push_back(mk(RT, FADD, 0, 1, 0, SID, B0, N4, 2, M0, 0));
    tbl.push_back(mk(RT, FADD, 0, 1, 0, SEX, B0, N4, 2, M0, 0));
    tbl.push_back(mk(RT, FADD, 0, 1, 0, SWB, B_WB, N4, 2, M0, 0));
    // ori with one fetch wait
    tbl.push_back(mk(ORI, 0, 0, 0, 0, SIF, B0, N4, 0, M0, 0));
    tbl.push_back(mk(ORI, 0, 0, 1, 0, SIF, B_IR, N4, 0, M0, 0));
    tbl.push_back(mk(ORI, 0, 0, 1, 0, SID, B0, N4, 4, M_ORI, 0));
    tbl.push_back(mk(ORI, 0, 0, 1, 0, SEX, B0, N4, 4, M_ORI, 0));
    tbl.push_back(mk(ORI, 0, 0, 1, 0, SWB, B_WB, N4, 4, M_ORI, 0));
    // jal, jr, j
    tbl.push_back(mk(JAL, 0, 0, 1, 0, SIF, B_IR, N4, 0, M0, 0));
    tbl.push_back(mk(JAL, 0, 0, 1, 0, SID, B_JL, 4'h1, 0, M0, 0));
    tbl.push_back(mk(RT, FJR, 0, 1, 0, SIF, B_IR, N4, 0, M0, 0));
    tbl.push_back(mk(RT, FJR, 0, 1, 0, SID, B_PC, 4'h8, 0, M0, 0));
    tbl.push_back(mk(JMP, 0, 0, 1, 0, SIF, B_IR, N4, 0, M0, 0));
    tbl.push_back(mk(JMP, 0, 0, 1, 0, SID, B_PC, 4'h0, 0, M0, 0));
    // branches
    tbl.push_back(mk(BEQ, 0, 1, 1, 0, SIF, B_IR, N4, 0, M0, 0));
    tbl.push_back(mk(BEQ, 0, 1, 1, 0, SID, B0, 4'h2, 6, M_BR, 0));
    tbl.push_back(mk(BEQ, 0, 1, 1, 0, SEX, B_PC, 4'h2, 6, M_BR, 0));
    tbl.push_back(mk(BEQ, 0, 0, 1, 0, SIF, B_IR, N4, 0, M0, 0));
    tbl.push_back(mk(BEQ, 0, 0, 1, 0, SID, B0, N4, 6, M_BR, 0));
    tbl.push_back(mk(BEQ, 0, 0, 1, 0, SEX, B_PC, N4, 6, M_BR, 0));
    tbl.push_back(mk(BNE, 0, 1, 1, 0, SIF, B_IR, N4, 0, M0, 0));
    tbl.push_back(mk(BNE, 0, 1, 1, 0, SID, B0, N4, 6, M_BR, 0));
    tbl.push_back(mk(BNE, 0, 1, 1, 0, SEX, B_PC, N4, 6, M_BR, 0));
    tbl.push_back(mk(BNE, 0, 0, 1, 0, SIF, B_IR, N4, 0, M0, 0));
    tbl.push_back(mk(BNE, 0, 0, 1, 0, SID, B0, 4'h3, 6, M_BR, 0));
    tbl.push_back(mk(BNE, 0, 0, 1, 0, SEX, B_PC, 4'h3, 6, M_BR, 0));
    // sw, zero wait
    tbl.push_back(mk(SW, 0, 0, 1, 0, SIF, B_IR, N4, 0, M0, 0));
    tbl.push_back(mk(SW, 0, 0, 1, 0, SID, B0, N4, 2, M_SW, 0));
    tbl.push_back(mk(SW, 0, 0, 1, 0, SEX, B0, N4, 2, M_SW, 0));
    tbl.push_back(mk(SW, 0, 0, 1, 1, SMEM, B_SW, N4, 2, M_SW, 0));
    // lw, three data waits
    tbl.push_back(mk(LW, 0, 0, 1, 0, SIF, B_IR, N4, 0, M0, 0));
    tbl.push_back(mk(LW, 0, 0, 1, 0, SID, B0, N4, 2, M_LW, 0));
    tbl.push_back(mk(LW, 0, 0, 1, 0, SEX, B0, N4, 2, M_LW, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(LW, 0, 0, 1, 0, SMEM, B_MR, N4, 2, M_LW, 0));
    tbl.push_back(mk(LW, 0, 0, 1, 1, SMEM, B_MR, N4, 2, M_LW, 0));
    tbl.push_back(mk(LW, 0, 0, 1, 0, SWB, B_WB, N4, 2, M_LW, 0));

    // reset state, with a fetch pending and a jal on the bus
    repeat (2) @(negedge clk);
    op = JAL;
    i_ready = 1'b1;
    #1;
    chk("rst/t0", act0, idle_e);
    chk("rst/t4", act4, idle_e);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], "tbl");

    // illegal op traps and stays quiet
    step(mk(BAD, 0, 0, 1, 0, SIF, B_IR, N4, 0, M0, 0), "ill_if");
    step(mk(BAD, 0, 0, 1, 0, SID, B0, N4, 0, M0, 0), "ill_id");
    for (int i = 0; i < 10; i++)
      step(mk(BAD, 0, 0, 1, 1, STRAP, B0, N4, 0, M0, 2'b10),
           "trap");

    // async reset mid-cycle clears flags at once
    #3;
    rst_n = 1'b0;
    op = JAL;
    i_ready = 1'b1;
    #1;
    chk("arst/t0", act0, idle_e);
    chk("arst/t4", act4, idle_e);
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(JAL, 0, 0, 1, 0, SIF, B_IR, N4, 0, M0, 0), "post");
    step(mk(JAL, 0, 0, 1, 0, SID, B_JL, 4'h1, 0, M0, 0), "post");

    // sw with d_ready stuck low: only the timeout DUT traps
    step(mk(SW, 0, 0, 1, 0, SIF, B_IR, N4, 0, M0, 0), "to_sw");
    step(mk(SW, 0, 0, 1, 0, SID, B0, N4, 2, M_SW, 0), "to_sw");
    step(mk(SW, 0, 0, 1, 0, SEX, B0, N4, 2, M_SW, 0), "to_sw");
    for (int i = 0; i < 4; i++)
      step(mk(SW, 0, 0, 1, 0, SMEM, B_MW, N4, 2, M_SW, 0),
           "to_wait");
    step(with4(mk(SW, 0, 0, 1, 0, SMEM, B_MW, N4, 2, M_SW, 0),
               trap_sw), "to_trap");
    do_reset();

    // ready on the last allowed wait cycle completes normally
    step(mk(SW, 0, 0, 1, 0, SIF, B_IR, N4, 0, M0, 0), "lim_sw");
    step(mk(SW, 0, 0, 1, 0, SID, B0, N4, 2, M_SW, 0), "lim_sw");
    step(mk(SW, 0, 0, 1, 0, SEX, B0, N4, 2, M_SW, 0), "lim_sw");
    for (int i = 0; i < 3; i++)
      step(mk(SW, 0, 0, 1, 0, SMEM, B_MW, N4, 2, M_SW, 0),
           "lim_wait");
    step(mk(SW, 0, 0, 1, 1, SMEM, B_SW, N4, 2, M_SW, 0),
         "lim_done");

    // instruction fetch stuck: timeout DUT traps after 4 waits
    for (int i = 0; i < 4; i++)
      step(mk(SW, 0, 0, 0, 0, SIF, B0, N4, 0, M0, 0), "if_wait");
    step(with4(mk(SW, 0, 0, 0, 0, SIF, B0, N4, 0, M0, 0),
               trap_sw), "if_trap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle successor to the single-cycle MIPS control decoder.
- An FSM sequences each instruction through IF/ID/EX/MEM/WB and drives the same datapath control set (RegDst, ALUSrc, MemtoReg, RegWr, MemWr, ExtOp, ALUctr, NPCop, if_branch), plus PC/IR write strobes.
- Adds BNE, JAL and JR, a ready-handshake to instruction and data memory, an optional memory-wait timeout, and an illegal-instruction trap.

Parameters:
- ALUCTR_W, 4, ALUctr width; encodings are zero-extended when wider.
- NPCOP_W, 4, NPCop width.
- MEM_TIMEOUT, 0, maximum wait cycles in IF/MEM before trapping; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- op  in  6  IR[31:26], stable from ID until return to IF.
- func  in  6  IR[5:0].
- zero  in  1  ALU zero flag, valid in EX.
- i_ready  in  1  instruction memory data valid.
- d_ready  in  1  data memory access complete.
- PCWr  out  1  PC load strobe, selected by NPCop.
- IRWr  out  1  instruction register load strobe.
- RegDst  out  1  0 = rd, 1 = rt.
- LinkWr  out  1  write $31 with PC+4 (JAL).
- ALUSrc  out  1  1 = immediate operand.
- MemtoReg  out  1  1 = write-back from data memory.
- RegWr  out  1  register file write strobe.
- MemRd  out  1  data memory read request.
- MemWr  out  1  data memory write request.
- ExtOp  out  1  1 = sign-extend, 0 = zero-extend.
- if_branch  out  1  shift immediate left by 2 (branch offset).
- ALUctr  out  ALUCTR_W  ALU operation.
- NPCop  out  NPCOP_W  next-PC select.
- illegal_instr  out  1  trap flag, sticky.
- bus_error  out  1  timeout flag, sticky.
- state  out  3  current FSM state, for debug.

Behaviour:
- Reset:
  - State goes to IF (0). illegal_instr, bus_error and the wait counter clear.
  - While rst_n is low, every strobe (PCWr, IRWr, RegWr, MemRd, MemWr, LinkWr) is 0.
- Encodings:
  - ALUctr: AND 0000, OR 0001, ADD 0010, XOR 0011, ORI 0100, ADDIU 0101, SUB 0110, ADDI 0111, SLL 1000, SLT 1001, LUI 1111.
  - NPCop: JUMP 0000, JAL 0001, BEQ 0010, BNE 0011, JR 1000, ADD4 1111.
  - States: IF 0, ID 1, EX 2, MEM 3, WB 4, TRAP 5.
- Static decode (combinational from op/func in every state except IF; in IF non-strobe outputs are 0 and NPCop = ADD4):
  - R-type (op 000000), by func: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100110 XOR, 000000 SLL, 001000 JR. RegDst 0, ALUSrc 0.
  - addiu 001001: ADDIU, ExtOp 1.
  - addi 001000: ADDI, ExtOp 1.
  - ori 001101: ORI, ExtOp 0.
  - lui 001111: LUI, ExtOp 0.
  - lw 100011: ADD, ExtOp 1, MemtoReg 1.
  - sw 101011: ADD, ExtOp 1.
  - All I-type above use RegDst 1, ALUSrc 1.
  - beq 000100 and bne 000101: SUB, ALUSrc 0, ExtOp 1, if_branch 1.
  - j 000010, jal 000011: no ALU use.
  - Any other op, or an undefined R-type func, is illegal.
- Transitions and strobes:
  - IF: hold until i_ready = 1, then IRWr = 1 for that cycle and go to ID.
  - ID, illegal instruction: go to TRAP.
  - ID, j: PCWr = 1, NPCop = JUMP, then IF.
  - ID, jal: PCWr = 1, NPCop = JAL, RegWr = 1, LinkWr = 1, then IF.
  - ID, jr: PCWr = 1, NPCop = JR, then IF.
  - ID, all others: go to EX.
  - EX, beq: PCWr = 1, NPCop = BEQ if zero = 1, else ADD4; then IF.
  - EX, bne: PCWr = 1, NPCop = BNE if zero = 0, else ADD4; then IF.
  - EX, lw/sw: go to MEM.
  - EX, arithmetic/logic: go to WB.
  - MEM: MemRd (lw) or MemWr (sw) held high until d_ready = 1.
    - sw on the ready cycle: PCWr = 1, NPCop = ADD4, then IF.
    - lw on the ready cycle: go to WB.
  - WB: RegWr = 1, PCWr = 1, NPCop = ADD4, then IF.
  - TRAP: all strobes 0; stays in TRAP until reset.
- Latency with zero-wait memory: j/jal/jr 2 cycles, beq/bne 3, R/I-arith 4, sw 4, lw 5. Each memory wait cycle adds 1.
- Timeout (MEM_TIMEOUT > 0):
  - The wait counter increments on each cycle in IF or MEM where ready = 0, and clears on state exit.
  - When the counter reaches MEM_TIMEOUT with ready still 0: go to TRAP, set bus_error, drop MemRd/MemWr.
  - Ready arriving on the same cycle as the limit wins (normal completion).
- Asynchronous reset mid-instruction aborts immediately; no partial strobe is emitted after reset deasserts.

Test Plan:
- add (op 0, func 100000) with i_ready = 1: states IF→ID→EX→WB→IF; RegWr = 1 only in cycle 4 with PCWr = 1, NPCop = 1111, ALUctr = 0010, RegDst = 0.
- lw with d_ready low for 3 MEM cycles: MemRd high for 4 cycles, then WB with RegWr = 1 and MemtoReg = 1; total 8 cycles.
- beq with zero = 1 → EX NPCop = 0010. bne with zero = 1 → NPCop = 1111. Both have PCWr = 1 and if_branch = 1.
- jal: 2 cycles; in ID, PCWr = RegWr = LinkWr = 1 and NPCop = 0001. jr (func 001000): NPCop = 1000 in ID.
- op 111111: ID→TRAP, illegal_instr = 1, no strobes for 10 cycles; rst_n pulse returns to IF with flags cleared.
- MEM_TIMEOUT = 4, sw with d_ready stuck at 0: TRAP after 4 wait cycles, bus_error = 1, MemWr drops. Repeat with d_ready = 1 on the 4th wait cycle: normal completion.
